relobi_a_other_checker: RTL and testbench

- Subordinate-side stage directly downstream of the A-channel "other"-field ECC encoder.
- Accepts an OBI A-channel beat carrying we/be/aid/a_optional plus other_ecc, and buffers it in a 2-entry skid buffer so that gnt_o is registered.
- Decodes the SECDED code on the buffer head, corrects single-bit errors and flags uncorrectable ones.
- Keeps a saturating corrected-error counter and a sticky fatal flag for the reliability status unit.

---
 rtl/relobi_a_other_checker_pkg.sv | 57 +++++
 rtl/hsiao_ecc_dec.sv | 46 ++++
 rtl/relobi_skid2.sv | 63 ++++++
 rtl/relobi_a_other_checker.sv | 97 +++++++++
 tb/tb_relobi_a_other_checker.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/relobi_a_other_checker_pkg.sv
// Shared types and sizing helpers for the A-channel "other"-field ECC checker.
// Column generation here must stay in lock-step with the matching encoder.
package relobi_a_other_checker_pkg;

  typedef struct packed {
    int unsigned DataWidth;
    int unsigned IdWidth;
    int unsigned AOptionalWidth;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{DataWidth: 32, IdWidth: 4, AOptionalWidth: 1};

  // Payload protected by the ECC: we + be + aid + a_optional.
  function automatic int unsigned relobi_a_other_width(obi_cfg_t cfg);
    return 1 + cfg.DataWidth / 8 + cfg.IdWidth + cfg.AOptionalWidth;
  endfunction

  // Smallest r with enough odd-weight (>=3) columns to cover k data bits.
  function automatic int unsigned secded_ecc_width(int unsigned k);
    int unsigned r;
    r = 3;
    while (((32'd1 << (r - 1)) - r) < k) r++;
    return r;
  endfunction

  function automatic int unsigned relobi_a_other_ecc_width(obi_cfg_t cfg);
    return secded_ecc_width(relobi_a_other_width(cfg));
  endfunction

  // Data column idx: the idx-th value, in ascending order, of odd weight >= 3.
  function automatic logic [31:0] hsiao_col(int unsigned idx, int unsigned r);
    int unsigned n;
    logic [31:0] col;
    n   = 0;
    col = '0;
    for (int unsigned v = 0; v < (32'd1 << r); v++) begin
      if (($countones(v) % 2 == 1) && ($countones(v) >= 3)) begin
        if (n == idx) col = 32'(v);
        n++;
      end
    end
    return col;
  endfunction

  localparam int unsigned DefBeWidth  = ObiDefaultConfig.DataWidth / 8;
  localparam int unsigned DefIdWidth  = ObiDefaultConfig.IdWidth;
  localparam int unsigned DefEccWidth = relobi_a_other_ecc_width(ObiDefaultConfig);

  typedef struct packed {
    logic [DefEccWidth-1:0] ecc;
    logic                   we;
    logic [DefBeWidth-1:0]  be;
    logic [DefIdWidth-1:0]  aid;
    logic                   a_optional;
  } relobi_a_other_t;

endpackage

// File: rtl/hsiao_ecc_dec.sv
// Hsiao SECDED decoder over {ecc, data}; check bits are identity columns.
module hsiao_ecc_dec import relobi_a_other_checker_pkg::*; #(
  parameter int unsigned DataWidth = 10,
  parameter int unsigned EccWidth  = 5
) (
  input  logic [EccWidth+DataWidth-1:0] in_i,
  output logic [DataWidth-1:0]          data_o,
  output logic [1:0]                    err_o    // [0] corrected, [1] uncorrectable
);

  logic [EccWidth-1:0]  cols [DataWidth];
  logic [EccWidth-1:0]  syndrome;
  logic [DataWidth-1:0] data_in;
  logic                 match;

  for (genvar g = 0; g < DataWidth; g++) begin : g_col
    assign cols[g] = EccWidth'(hsiao_col(g, EccWidth));
  end

  assign data_in = in_i[DataWidth-1:0];

  always_comb begin
    syndrome = in_i[EccWidth+DataWidth-1:DataWidth];
    for (int unsigned i = 0; i < DataWidth; i++) begin
      if (data_in[i]) syndrome = syndrome ^ cols[i];
    end
  end

  // A one-hot syndrome points at a check bit: count it, leave data alone.
  always_comb begin
    data_o = data_in;
    match  = 1'b0;
    err_o  = 2'b00;
    for (int unsigned i = 0; i < DataWidth; i++) begin
      if (syndrome == cols[i]) begin
        data_o[i] = ~data_in[i];
        match     = 1'b1;
      end
    end
    if (syndrome != '0) begin
      if (match || ((syndrome & (syndrome - EccWidth'(1))) == '0)) err_o[0] = 1'b1;
      else                                                          err_o[1] = 1'b1;
    end
  end

endmodule

// File: rtl/relobi_skid2.sv
// Generic 2-entry register buffer; ready_o is a flop so no path from ready_i.
module relobi_skid2 #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] data_o
);

  logic [Width-1:0] mem_q [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             push, pop;

  assign push    = valid_i & ready_q;
  assign pop     = valid_o & ready_i;
  assign valid_o = (cnt_q != 2'd0);
  assign ready_o = ready_q;
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d = pop ? ~rd_ptr_q : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
    ready_d = (cnt_d < 2'd2);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      ready_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/relobi_a_other_checker.sv
// Buffers an ECC-protected OBI A-channel beat, corrects it at the head and
// tracks corrected/uncorrectable hand-offs for the reliability status unit.
module relobi_a_other_checker import relobi_a_other_checker_pkg::*; #(
  parameter obi_cfg_t    Cfg           = ObiDefaultConfig,
  parameter type         a_optional_t  = logic,
  parameter int unsigned OtherEccWidth = relobi_a_other_ecc_width(Cfg),
  parameter int unsigned CntWidth      = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clear_i,
  input  logic                         req_i,
  output logic                         gnt_o,
  input  logic                         we_i,
  input  logic [Cfg.DataWidth/8-1:0]   be_i,
  input  logic [Cfg.IdWidth-1:0]       aid_i,
  input  a_optional_t                  a_optional_i,
  input  logic [OtherEccWidth-1:0]     other_ecc_i,
  output logic                         req_o,
  input  logic                         gnt_i,
  output logic                         we_o,
  output logic [Cfg.DataWidth/8-1:0]   be_o,
  output logic [Cfg.IdWidth-1:0]       aid_o,
  output a_optional_t                  a_optional_o,
  output logic                         single_err_o,
  output logic                         multi_err_o,
  output logic [CntWidth-1:0]          corr_cnt_o,
  output logic                         fatal_o
);

  localparam int unsigned DataW  = 1 + Cfg.DataWidth / 8 + Cfg.IdWidth + $bits(a_optional_t);
  localparam int unsigned EntryW = OtherEccWidth + DataW;
  localparam logic [CntWidth-1:0] CntMax = '1;

  logic [EntryW-1:0]   in_entry, head_entry;
  logic [DataW-1:0]    head_data;
  logic [1:0]          dec_err;
  logic                handoff;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                fatal_q, fatal_d;

  // Stored raw so the ECC keeps protecting the beat while it sits in the buffer.
  assign in_entry = {other_ecc_i, we_i, be_i, aid_i, a_optional_i};

  relobi_skid2 #(
    .Width (EntryW)
  ) u_skid (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (req_i),
    .ready_o (gnt_o),
    .data_i  (in_entry),
    .valid_o (req_o),
    .ready_i (gnt_i),
    .data_o  (head_entry)
  );

  hsiao_ecc_dec #(
    .DataWidth (DataW),
    .EccWidth  (OtherEccWidth)
  ) u_dec (
    .in_i   (head_entry),
    .data_o (head_data),
    .err_o  (dec_err)
  );

  assign {we_o, be_o, aid_o, a_optional_o} = head_data;
  assign single_err_o = req_o & dec_err[0];
  assign multi_err_o  = req_o & dec_err[1];
  assign handoff      = req_o & gnt_i;

  always_comb begin
    cnt_d   = cnt_q;
    fatal_d = fatal_q;
    if (clear_i) begin
      cnt_d   = '0;
      fatal_d = 1'b0;
    end else if (handoff) begin
      if (single_err_o && (cnt_q != CntMax)) cnt_d = cnt_q + CntWidth'(1);
      if (multi_err_o) fatal_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      fatal_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      fatal_q <= fatal_d;
    end
  end

  assign corr_cnt_o = cnt_q;
  assign fatal_o    = fatal_q;

endmodule

// File: tb/tb_relobi_a_other_checker.sv
// Directed bench for relobi_a_other_checker: default instance plus a CntWidth=2 copy.
module tb_relobi_a_other_checker;

  // Hsiao data columns for 10 data bits / 5 check bits, bit 0 in the LSBs.
  localparam logic [49:0] Cols = {5'd28, 5'd26, 5'd25, 5'd22, 5'd21,
                                  5'd19, 5'd14, 5'd13, 5'd11, 5'd7};

  logic clk, rst, clear;
  logic req_in, gnt_in;
  logic we_in, aopt_in;
  logic [3:0] be_in, aid_in;
  logic [4:0] ecc_in;

  logic gnt_out, req_out, we_out, aopt_out, single, multi, fatal;
  logic [3:0] be_out, aid_out;
  logic [7:0] cnt;
  logic s_gnt, s_req, s_we, s_aopt, s_single, s_multi, s_fatal;
  logic [3:0] s_be, s_aid;
  logic [1:0] s_cnt;

  int checks;
  int failures;

  relobi_a_other_checker dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .req_i(req_in), .gnt_o(gnt_out),
    .we_i(we_in), .be_i(be_in), .aid_i(aid_in), .a_optional_i(aopt_in),
    .other_ecc_i(ecc_in), .req_o(req_out), .gnt_i(gnt_in), .we_o(we_out), .be_o(be_out),
    .aid_o(aid_out), .a_optional_o(aopt_out), .single_err_o(single), .multi_err_o(multi),
    .corr_cnt_o(cnt), .fatal_o(fatal)
  );

  relobi_a_other_checker #(.CntWidth(2)) dut_sat (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .req_i(req_in), .gnt_o(s_gnt),
    .we_i(we_in), .be_i(be_in), .aid_i(aid_in), .a_optional_i(aopt_in),
    .other_ecc_i(ecc_in), .req_o(s_req), .gnt_i(gnt_in), .we_o(s_we), .be_o(s_be),
    .aid_o(s_aid), .a_optional_o(s_aopt), .single_err_o(s_single), .multi_err_o(s_multi),
    .corr_cnt_o(s_cnt), .fatal_o(s_fatal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] enc(input logic [9:0] d);
    logic [4:0] e;
    e = '0;
    for (int i = 0; i < 10; i++) if (d[i]) e = e ^ Cols[i*5 +: 5];
    return e;
  endfunction

  // Drive a beat encoded from clean fields, then corrupt data/check bits as asked.
  task automatic set_beat(input logic w, input logic [3:0] b, input logic [3:0] a,
                          input logic o, input logic [9:0] dflip, input logic [4:0] eflip);
    logic [9:0] d;
    d = {w, b, a, o};
    ecc_in = enc(d) ^ eflip;
    d = d ^ dflip;
    {we_in, be_in, aid_in, aopt_in} = d;
    req_in = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (req_out !== 1'b0) begin failures++; $display("FAIL rst_req got=%0b exp=0", req_out); end
    checks++; if (gnt_out !== 1'b1) begin failures++; $display("FAIL rst_gnt got=%0b exp=1", gnt_out); end
    checks++; if (cnt !== 8'd0) begin failures++; $display("FAIL rst_cnt got=%0d exp=0", cnt); end
    checks++; if (fatal !== 1'b0) begin failures++; $display("FAIL rst_fatal got=%0b exp=0", fatal); end
    checks++; if ({we_out, be_out, aid_out, aopt_out} !== 10'd0) begin
      failures++; $display("FAIL rst_data got=%h exp=0", {we_out, be_out, aid_out, aopt_out}); end
    #3 rst = 1'b0;
  endtask

  task automatic test_single_beat();
    gnt_in = 1'b0;
    set_beat(1'b1, 4'hF, 4'd3, 1'b0, 10'd0, 5'd0);
    step();
    req_in = 1'b0;
    checks++; if (req_out !== 1'b1) begin failures++; $display("FAIL sb_req got=%0b exp=1", req_out); end
    checks++; if ({we_out, be_out, aid_out} !== {1'b1, 4'hF, 4'd3}) begin failures++;
      $display("FAIL sb_fields got=%h exp=%h", {we_out, be_out, aid_out}, {1'b1, 4'hF, 4'd3}); end
    checks++; if (single !== 1'b0 || multi !== 1'b0) begin failures++;
      $display("FAIL sb_err got=%0b%0b exp=00", single, multi); end
    gnt_in = 1'b1;
    step();
    checks++; if (req_out !== 1'b0) begin failures++; $display("FAIL sb_pop got=%0b exp=0", req_out); end
    checks++; if (cnt !== 8'd0) begin failures++; $display("FAIL sb_cnt got=%0d exp=0", cnt); end
  endtask

  task automatic test_back_pressure();
    gnt_in = 1'b0;
    set_beat(1'b0, 4'h1, 4'd1, 1'b0, 10'd0, 5'd0);
    step();
    set_beat(1'b0, 4'h2, 4'd2, 1'b0, 10'd0, 5'd0);
    step();
    checks++; if (gnt_out !== 1'b0) begin failures++; $display("FAIL bp_full got=%0b exp=0", gnt_out); end
    set_beat(1'b0, 4'h3, 4'd3, 1'b0, 10'd0, 5'd0);
    step();
    checks++; if (aid_out !== 4'd1) begin failures++; $display("FAIL bp_hold got=%0d exp=1", aid_out); end
    checks++; if (gnt_out !== 1'b0) begin failures++; $display("FAIL bp_stall got=%0b exp=0", gnt_out); end
    gnt_in = 1'b1;
    step();
    checks++; if (aid_out !== 4'd2 || be_out !== 4'h2) begin failures++;
      $display("FAIL bp_second got=%0d exp=2", aid_out); end
    checks++; if (gnt_out !== 1'b1) begin failures++; $display("FAIL bp_regnt got=%0b exp=1", gnt_out); end
    step();
    req_in = 1'b0;
    checks++; if (aid_out !== 4'd3 || req_out !== 1'b1) begin failures++;
      $display("FAIL bp_third got=%0d/%0b exp=3/1", aid_out, req_out); end
    step();
    checks++; if (req_out !== 1'b0) begin failures++; $display("FAIL bp_drain got=%0b exp=0", req_out); end
  endtask

  task automatic test_data_flip();
    gnt_in = 1'b0;
    set_beat(1'b1, 4'hF, 4'd3, 1'b0, 10'b0010000000, 5'd0);
    step();
    req_in = 1'b0;
    checks++; if (be_out !== 4'hF) begin failures++; $display("FAIL df_be got=%h exp=F", be_out); end
    checks++; if (single !== 1'b1 || multi !== 1'b0) begin failures++;
      $display("FAIL df_err got=%0b%0b exp=10", single, multi); end
    checks++; if (cnt !== 8'd0) begin failures++; $display("FAIL df_cnt0 got=%0d exp=0", cnt); end
    gnt_in = 1'b1;
    step();
    checks++; if (cnt !== 8'd1) begin failures++; $display("FAIL df_cnt1 got=%0d exp=1", cnt); end
  endtask

  task automatic test_check_flip();
    gnt_in = 1'b0;
    set_beat(1'b0, 4'h5, 4'd9, 1'b1, 10'd0, 5'b00001);
    step();
    req_in = 1'b0;
    checks++; if ({we_out, be_out, aid_out, aopt_out} !== {1'b0, 4'h5, 4'd9, 1'b1}) begin
      failures++; $display("FAIL cf_fields got=%h exp=%h",
                           {we_out, be_out, aid_out, aopt_out}, {1'b0, 4'h5, 4'd9, 1'b1}); end
    checks++; if (single !== 1'b1 || multi !== 1'b0) begin failures++;
      $display("FAIL cf_err got=%0b%0b exp=10", single, multi); end
    gnt_in = 1'b1;
    step();
    checks++; if (cnt !== 8'd2) begin failures++; $display("FAIL cf_cnt got=%0d exp=2", cnt); end
  endtask

  task automatic test_double_flip();
    gnt_in = 1'b0;
    set_beat(1'b0, 4'hA, 4'd6, 1'b0, 10'b1000000001, 5'd0);
    step();
    req_in = 1'b0;
    checks++; if (multi !== 1'b1 || single !== 1'b0) begin failures++;
      $display("FAIL dd_err got=%0b%0b exp=01", single, multi); end
    checks++; if ({we_out, aopt_out} !== 2'b11) begin failures++;
      $display("FAIL dd_raw got=%b exp=11", {we_out, aopt_out}); end
    checks++; if (fatal !== 1'b0) begin failures++; $display("FAIL dd_early got=%0b exp=0", fatal); end
    gnt_in = 1'b1;
    step();
    checks++; if (fatal !== 1'b1) begin failures++; $display("FAIL dd_fatal got=%0b exp=1", fatal); end
    checks++; if (cnt !== 8'd2) begin failures++; $display("FAIL dd_cnt got=%0d exp=2", cnt); end
    clear = 1'b1;
    step();
    clear = 1'b0;
    checks++; if (fatal !== 1'b0 || cnt !== 8'd0) begin failures++;
      $display("FAIL dd_clear got=%0b/%0d exp=0/0", fatal, cnt); end
  endtask

  task automatic test_clear_wins();
    gnt_in = 1'b0;
    set_beat(1'b1, 4'h8, 4'd4, 1'b1, 10'b0000000100, 5'd0);
    step();
    req_in = 1'b0;
    checks++; if (single !== 1'b1 || aid_out !== 4'd4) begin failures++;
      $display("FAIL cw_pre got=%0b/%0d exp=1/4", single, aid_out); end
    gnt_in = 1'b1;
    clear  = 1'b1;
    step();
    clear = 1'b0;
    checks++; if (cnt !== 8'd0 || req_out !== 1'b0) begin failures++;
      $display("FAIL cw_cnt got=%0d/%0b exp=0/0", cnt, req_out); end
  endtask

  // Streamed single-error beats: each cycle pops one and accepts the next.
  task automatic test_back_to_back();
    logic [1:0] sat_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    gnt_in = 1'b1;
    set_beat(1'b0, 4'h3, 4'd1, 1'b0, 10'd1 << 1, 5'd0);
    step();
    for (int i = 1; i <= 5; i++) begin
      checks++; if (aid_out !== 4'(i) || single !== 1'b1) begin failures++;
        $display("FAIL b2b_head%0d got=%0d/%0b exp=%0d/1", i, aid_out, single, i); end
      if (i < 5) set_beat(1'b0, 4'h3, 4'(i + 1), 1'b0, 10'd1 << i, 5'd0);
      else req_in = 1'b0;
      step();
      checks++; if (s_cnt !== sat_exp[i-1]) begin failures++;
        $display("FAIL sat_cnt%0d got=%0d exp=%0d", i, s_cnt, sat_exp[i-1]); end
      checks++; if (cnt !== 8'(i)) begin failures++;
        $display("FAIL b2b_cnt%0d got=%0d exp=%0d", i, cnt, i); end
    end
    checks++; if (req_out !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%0b exp=0", req_out); end
  endtask

  task automatic test_async_reset();
    gnt_in = 1'b0;
    set_beat(1'b1, 4'h1, 4'd1, 1'b0, 10'd0, 5'd0);
    step();
    set_beat(1'b1, 4'h2, 4'd2, 1'b0, 10'd0, 5'd0);
    step();
    req_in = 1'b0;
    checks++; if (gnt_out !== 1'b0 || req_out !== 1'b1) begin failures++;
      $display("FAIL ar_pre got=%0b/%0b exp=0/1", gnt_out, req_out); end
    #2 rst = 1'b1;
    #1;
    checks++; if (req_out !== 1'b0) begin failures++; $display("FAIL ar_req got=%0b exp=0", req_out); end
    checks++; if (cnt !== 8'd0 || s_cnt !== 2'd0) begin failures++;
      $display("FAIL ar_cnt got=%0d/%0d exp=0/0", cnt, s_cnt); end
    checks++; if (gnt_out !== 1'b1) begin failures++; $display("FAIL ar_gnt got=%0b exp=1", gnt_out); end
    #1 rst = 1'b0;
    step();
    checks++; if (req_out !== 1'b0 || gnt_out !== 1'b1) begin failures++;
      $display("FAIL ar_after got=%0b/%0b exp=0/1", req_out, gnt_out); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    clear    = 1'b0;
    req_in   = 1'b0;
    gnt_in   = 1'b0;
    we_in    = 1'b0;
    be_in    = '0;
    aid_in   = '0;
    aopt_in  = 1'b0;
    ecc_in   = '0;
    test_reset();
    test_single_beat();
    test_back_pressure();
    test_data_flip();
    test_check_flip();
    test_double_flip();
    test_clear_wins();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
